// File: rtl/state_col_reader.sv
// Column-serialising reader: captures a 128-bit state and presents its four 32-bit columns one per handshake.
// Optional feature: define STATE_COL_READER_KEY_XOR_EN to XOR each column with the captured round-key word.
module state_col_reader (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] data_in,
  input  logic [31:0]  key_in,
  input  logic         ready_in,
  output logic         valid_out,
  output logic [7:0]   out_1,
  output logic [7:0]   out_2,
  output logic [7:0]   out_3,
  output logic [7:0]   out_4,
  output logic [1:0]   i,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [127:0] data_q;
  logic [31:0]  col;
  logic         capture;
  logic         xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture    = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (ready_in) begin
          xfer = 1'b1;
          if (i == 2'd3) state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      i      <= '0;
    end else if (capture) begin
      data_q <= data_in;
      i      <= '0;
    end else if (xfer) begin
      i <= i + 2'd1;  // 3 -> 0 wrap coincides with entering FIN
    end
  end

  always_comb begin
    col = '0;
    case (i)
      2'd0: col = data_q[127:96];
      2'd1: col = data_q[95:64];
      2'd2: col = data_q[63:32];
      2'd3: col = data_q[31:0];
      default: col = '0;
    endcase
  end

`ifdef STATE_COL_READER_KEY_XOR_EN
  logic [31:0] key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          key_q <= '0;
    else if (capture) key_q <= key_in;
  end

  assign {out_1, out_2, out_3, out_4} = col ^ key_q;
`else
  logic unused_key;
  assign unused_key = ^key_in;

  assign {out_1, out_2, out_3, out_4} = col;
`endif

  assign valid_out = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_state_col_reader.sv
// Scoreboard bench for state_col_reader: stimulus queues expected {i, column}; a negedge monitor checks each transfer.
module tb_state_col_reader;

  localparam logic [127:0] BLK_A = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] BLK_B = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [31:0]  KEY   = 32'h2b7e1516;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [127:0] data_in;
  logic [31:0]  key_in;
  logic         ready_in;
  logic         valid_out;
  logic [7:0]   out_1, out_2, out_3, out_4;
  logic [1:0]   col_i;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  logic [33:0] sb[$];
  bit pend_done = 1'b0;

  state_col_reader dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .key_in(key_in),
    .ready_in(ready_in), .valid_out(valid_out), .out_1(out_1), .out_2(out_2),
    .out_3(out_3), .out_4(out_4), .i(col_i), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_col(input logic [127:0] blk, input int k);
    logic [31:0] c;
    c = blk[127 - 32*k -: 32];
`ifdef STATE_COL_READER_KEY_XOR_EN
    c = c ^ KEY;
`endif
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_block(input logic [127:0] blk);
    for (int k = 0; k < 4; k++) sb.push_back({2'(k), exp_col(blk, k)});
  endtask

  // called #1 after an edge while the DUT is idle
  task automatic load_block(input logic [127:0] blk);
    load    = 1'b1;
    data_in = blk;
    push_block(blk);
    @(posedge clk); #1;
    load    = 1'b0;
    data_in = '0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pend_done = 1'b0;
    end else begin
      if (pend_done) begin
        chk("done_after_col3", 64'(done), 64'd1);
        pend_done = 1'b0;
      end
      if (valid_out && ready_in) begin
        if (sb.size() == 0) begin
          chk("unexpected_transfer", {30'd0, col_i, out_1, out_2, out_3, out_4}, 64'hdead);
        end else begin
          logic [33:0] e;
          e = sb.pop_front();
          chk("column", 64'({col_i, out_1, out_2, out_3, out_4}), 64'(e));
          if (e[33:32] == 2'd3) pend_done = 1'b1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; ready_in = 1'b1; data_in = '0; key_in = KEY;
    #2;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_i", 64'(col_i), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'({out_1, out_2, out_3, out_4}), 64'd0);

    // load on the very first edge after reset release, full-rate emission
    #1 rst = 1'b0;
    load = 1'b1; data_in = BLK_A; push_block(BLK_A);
    @(posedge clk); #1;
    load = 1'b0; data_in = '0;
    chk("first_valid", 64'(valid_out), 64'd1);
    chk("first_busy", 64'(busy), 64'd1);
    chk("first_i", 64'(col_i), 64'd0);
    chk("first_col", 64'({out_1, out_2, out_3, out_4}), 64'(exp_col(BLK_A, 0)));
`ifdef STATE_COL_READER_KEY_XOR_EN
    chk("xor_col0", 64'({out_1, out_2, out_3, out_4}), 64'h193de3be);
`else
    chk("raw_col0", 64'({out_1, out_2, out_3, out_4}), 64'h3243f6a8);
`endif
    repeat (3) begin @(posedge clk); #1; end
    chk("cyc4_i", 64'(col_i), 64'd3);
    chk("cyc4_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("cyc5_done", 64'(done), 64'd1);
    chk("cyc5_valid", 64'(valid_out), 64'd0);
    chk("cyc5_i", 64'(col_i), 64'd0);
    @(posedge clk); #1;
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("idle_hold_out", 64'({out_1, out_2, out_3, out_4}), 64'(exp_col(BLK_A, 0)));
    chk("idle_hold_valid", 64'(valid_out), 64'd0);

    // stall three cycles at column 1
    load_block(BLK_A);
    @(posedge clk); #1;
    ready_in = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_i", 64'(col_i), 64'd1);
      chk("stall_out", 64'({out_1, out_2, out_3, out_4}), 64'(exp_col(BLK_A, 1)));
      chk("stall_valid", 64'(valid_out), 64'd1);
    end
    ready_in = 1'b1;
    wait_done();
    @(posedge clk); #1;

    // load pulse mid-emission must be ignored
    load_block(BLK_A);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ign_i", 64'(col_i), 64'd2);
    load = 1'b1; data_in = '1;
    @(posedge clk); #1;
    load = 1'b0; data_in = '0;
    wait_done();
    @(posedge clk); #1;
    chk("ign_idle", 64'(busy), 64'd0);

    // asynchronous reset between edges at column 2
    load_block(BLK_A);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_i", 64'(col_i), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(valid_out), 64'd0);
    chk("arst_i", 64'(col_i), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out", 64'({out_1, out_2, out_3, out_4}), 64'd0);
    sb.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    load_block(BLK_B);
    chk("post_rst_i", 64'(col_i), 64'd0);
    chk("post_rst_col", 64'({out_1, out_2, out_3, out_4}), 64'(exp_col(BLK_B, 0)));
    wait_done();
    @(posedge clk); #1;

    // back-to-back: load in the idle cycle right after FIN
    load_block(BLK_A);
    wait_done();
    @(posedge clk); #1;
    chk("b2b_idle", 64'(busy), 64'd0);
    load_block(BLK_B);
    chk("b2b_valid", 64'(valid_out), 64'd1);
    chk("b2b_i", 64'(col_i), 64'd0);
    chk("b2b_col", 64'({out_1, out_2, out_3, out_4}), 64'(exp_col(BLK_B, 0)));
    wait_done();
    @(posedge clk); #1;

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
